// File: rtl/vfetch_if.sv
// Bundle of frame/line control, memory read port and unpack-buffer write port.
// Latency: none, wiring only.
// Backpressure: memory side is a level request held until a one-cycle acknowledge.
interface vfetch_if #(
    parameter int AWIDTH = 16
);
    logic              FrameStart;
    logic              LineStart;
    logic [AWIDTH-1:0] BaseAddr;

    logic              MemReq;
    logic [AWIDTH-1:0] MemAddr;
    logic              MemAck;
    logic [7:0]        MemData;

    logic [1:0]        ReadIndex;
    logic [1:0]        WriteIndex;
    logic [7:0]        DataOut;
    logic              ReqWrite;
    logic              Underrun;

    // Fetch sequencer side.
    modport master (
        input  FrameStart, LineStart, BaseAddr, MemAck, MemData,
        output MemReq, MemAddr, ReadIndex, WriteIndex, DataOut, ReqWrite, Underrun
    );

    // Environment side: frame timing, video memory and unpack buffer.
    modport slave (
        output FrameStart, LineStart, BaseAddr, MemAck, MemData,
        input  MemReq, MemAddr, ReadIndex, WriteIndex, DataOut, ReqWrite, Underrun
    );
endinterface

// File: rtl/vfetch.sv
// Video fetch sequencer: prefetches 6-bpp pixel bytes into a 4-entry FIFO and writes 3 bytes per 4-pixel group.
// Latency: a byte reaches DataOut at the first write slot after it becomes FIFO head; ReqWrite pulses 1 cycle.
// Backpressure: one memory request in flight, issued only while the FIFO has room; empty FIFO at a slot sets Underrun.
module vfetch #(
    parameter int AWIDTH  = 16,
    parameter int HGROUPS = 160
) (
    input  logic     PixelClk,
    input  logic     Reset,
    vfetch_if.master bus
);
    localparam int            GW        = $clog2(HGROUPS + 1);
    localparam logic [GW-1:0] GROUP_END = GW'(HGROUPS);

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_REQ  = 1'b1
    } rd_state_t;

    rd_state_t         rd_state;
    rd_state_t         rd_state_nxt;
    logic              accept;      // MemAck for a live request: byte enters the FIFO
    logic              drop;        // FrameStart abandons a live request
    logic              discard;     // an abandoned request still owes its MemAck
    logic [AWIDTH-1:0] fetch_addr;

    logic [7:0]        fifo_mem [4];
    logic [1:0]        rd_ptr;
    logic [1:0]        wr_ptr;
    logic [2:0]        count;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    logic [2:0]        phase;
    logic [GW-1:0]     group_cnt;
    logic              slot;        // this edge is a write slot (Phase 1->2, 3->4, 5->6)
    logic              starve;      // slot with nothing to write
    logic [1:0]        slot_idx;

    logic              req_write;
    logic [1:0]        write_index;
    logic [7:0]        data_out;
    logic              underrun;

    // Slot decode. A LineStart edge restarts Phase, so it never doubles as a slot edge.
    assign slot       = !bus.LineStart && phase[0] && (phase != 3'd7) && (group_cnt < GROUP_END);
    assign slot_idx   = phase[2:1];
    assign fifo_empty = (count == 3'd0);
    assign pop        = slot && !fifo_empty;
    assign starve     = slot && fifo_empty;
    // A byte acknowledged in the slot cycle lands behind the head; it cannot rescue an empty slot.
    assign push       = accept;

    // Reader next state: request whenever there is room, retire on MemAck, FrameStart aborts.
    always_comb begin
        rd_state_nxt = rd_state;
        accept       = 1'b0;
        drop         = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                // The in-flight byte always has a reserved FIFO entry, so only free entries count.
                if (!discard && (count < 3'd4)) begin
                    rd_state_nxt = RD_REQ;
                end
            end
            RD_REQ: begin
                if (bus.MemAck) begin
                    rd_state_nxt = RD_IDLE;
                    accept       = 1'b1;
                end
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
        // A byte acknowledged on the FrameStart edge belongs to the old frame and is dropped.
        if (bus.FrameStart) begin
            drop         = (rd_state == RD_REQ) && !bus.MemAck;
            accept       = 1'b0;
            rd_state_nxt = RD_IDLE;
        end
    end

    // Reader state register.
    always_ff @(posedge PixelClk) begin
        if (Reset) begin
            rd_state <= RD_IDLE;
        end else begin
            rd_state <= rd_state_nxt;
        end
    end

    // Track a request abandoned by FrameStart until its late MemAck has been swallowed.
    always_ff @(posedge PixelClk) begin
        if (Reset) begin
            discard <= 1'b0;
        end else if (drop) begin
            discard <= 1'b1;
        end else if (discard && bus.MemAck) begin
            discard <= 1'b0;
        end
    end

    // Fetch address: reloaded per frame only, runs on through blanking and wraps naturally.
    always_ff @(posedge PixelClk) begin
        if (Reset) begin
            fetch_addr <= '0;
        end else if (bus.FrameStart) begin
            fetch_addr <= bus.BaseAddr;
        end else if (accept) begin
            fetch_addr <= fetch_addr + 1'b1;
        end
    end

    // FIFO storage; contents need no reset because count guards every read.
    always_ff @(posedge PixelClk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.MemData;
        end
    end

    // FIFO pointers and occupancy; FrameStart flush wins over a same-cycle push or pop.
    always_ff @(posedge PixelClk) begin
        if (Reset || bus.FrameStart) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (push && !pop) begin
                count <= count + 3'd1;
            end else if (pop && !push) begin
                count <= count - 3'd1;
            end
        end
    end

    // Pixel phase and group counter; idle (saturated) until the first LineStart.
    always_ff @(posedge PixelClk) begin
        if (Reset) begin
            phase     <= 3'd0;
            group_cnt <= GROUP_END;
        end else if (bus.LineStart) begin
            phase     <= 3'd0;
            group_cnt <= '0;
        end else begin
            phase <= phase + 3'd1;
            if ((phase == 3'd7) && (group_cnt < GROUP_END)) begin
                group_cnt <= group_cnt + 1'b1;
            end
        end
    end

    // Write port: one-cycle strobe per slot; index and data hold until the next slot.
    always_ff @(posedge PixelClk) begin
        if (Reset) begin
            req_write   <= 1'b0;
            write_index <= 2'd0;
            data_out    <= 8'h00;
        end else begin
            req_write <= slot;
            if (slot) begin
                write_index <= slot_idx;
                data_out    <= fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
            end
        end
    end

    // Sticky underrun flag; only a new frame can clear it since the byte stream is now misaligned.
    always_ff @(posedge PixelClk) begin
        if (Reset || bus.FrameStart) begin
            underrun <= 1'b0;
        end else if (starve) begin
            underrun <= 1'b1;
        end
    end

    assign bus.MemReq     = (rd_state == RD_REQ);
    assign bus.MemAddr    = fetch_addr;
    assign bus.ReadIndex  = phase[2:1];
    assign bus.WriteIndex = write_index;
    assign bus.DataOut    = data_out;
    assign bus.ReqWrite   = req_write;
    assign bus.Underrun   = underrun;
endmodule

// File: tb/tb_vfetch.sv
// Testbench for vfetch: directed frame/line scenarios plus randomized memory latency and timing.
// Latency: expectations come from a queue-based model stepped on each rising edge.
// Backpressure: a bench memory responder acknowledges requests after a chosen latency.
module tb_vfetch;
    localparam int AW = 16;
    localparam int HG = 4;

    logic PixelClk = 1'b0;
    logic Reset;

    vfetch_if #(.AWIDTH(AW)) bus ();

    vfetch #(.AWIDTH(AW), .HGROUPS(HG)) dut (
        .PixelClk (PixelClk),
        .Reset    (Reset),
        .bus      (bus)
    );

    always #5 PixelClk = ~PixelClk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // stimulus requests for the next cycle
    bit          rst_q;
    bit          fs_q;
    bit          ls_q;
    logic [15:0] base_q;

    // memory responder
    bit          pend;
    int          waitc;
    logic [15:0] paddr;
    int          lat_fix;
    bit          lat_rand;
    int          lat_max;

    // reference model
    logic [7:0]  m_fifo [$];
    int          m_phase;
    int          m_gcnt;
    logic [15:0] m_fetch;
    bit          m_req;
    bit          m_disc;
    bit          m_und;
    bit          m_rw;
    logic [1:0]  m_wi;
    logic [7:0]  m_do;
    bit          model_valid = 1'b0;

    // scenario scratch
    int pulses;
    int reqs;
    bit prev;
    bit found;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // One clock of the specified behaviour, stated over a byte queue.
    task automatic model_step(input bit rst, input bit fs, input bit ls, input logic [15:0] base,
                              input bit ack, input logic [7:0] dat);
        int pre_size;
        bit was_req;
        bit slot;
        if (rst) begin
            m_fifo.delete();
            m_phase = 0; m_gcnt = HG; m_fetch = 16'h0000;
            m_req = 0; m_disc = 0; m_und = 0; m_rw = 0; m_wi = 2'd0; m_do = 8'h00;
            model_valid = 1'b1;
            return;
        end
        pre_size = m_fifo.size();
        was_req  = m_req;
        slot     = !ls && (m_phase == 1 || m_phase == 3 || m_phase == 5) && (m_gcnt < HG);
        m_rw = slot;
        if (slot) begin
            m_wi = 2'(m_phase / 2);
            if (pre_size > 0) begin
                m_do = m_fifo.pop_front();
            end else begin
                m_do  = 8'h00;
                m_und = 1'b1;
            end
        end
        if (was_req) begin
            if (ack) begin
                m_fifo.push_back(dat);
                m_fetch = m_fetch + 16'd1;
                m_req   = 1'b0;
            end
        end else if (m_disc) begin
            if (ack) m_disc = 1'b0;
        end else if (pre_size < 4) begin
            m_req = 1'b1;
        end
        if (fs) begin
            m_fetch = base;
            m_fifo.delete();
            m_und = 1'b0;
            if (was_req && !ack) m_disc = 1'b1;
            m_req = 1'b0;
        end
        if (ls) begin
            m_phase = 0;
            m_gcnt  = 0;
        end else begin
            if (m_phase == 7 && m_gcnt < HG) m_gcnt++;
            m_phase = (m_phase + 1) % 8;
        end
    endtask

    // Model advances on the same edge as the DUT, from the inputs held across it.
    always @(posedge PixelClk) begin
        model_step(Reset, bus.FrameStart, bus.LineStart, bus.BaseAddr, bus.MemAck, bus.MemData);
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge PixelClk) begin
        if (model_valid) begin
            chk("MemReq", bus.MemReq, m_req);
            if (m_req) chk("MemAddr", bus.MemAddr, m_fetch);
            chk("ReadIndex", bus.ReadIndex, m_phase >> 1);
            chk("ReqWrite", bus.ReqWrite, m_rw);
            chk("WriteIndex", bus.WriteIndex, m_wi);
            chk("DataOut", bus.DataOut, m_do);
            chk("Underrun", bus.Underrun, m_und);
        end
    end

    // Memory model: data byte is the low address byte, returned after the chosen latency.
    task automatic respond();
        if (rst_q) begin
            pend       = 1'b0;
            bus.MemAck = 1'b0;
        end else begin
            if (!pend && bus.MemReq === 1'b1) begin
                pend  = 1'b1;
                paddr = bus.MemAddr;
                waitc = lat_rand ? int'($urandom_range(lat_max, 0)) : lat_fix;
            end
            if (pend && waitc == 0) begin
                bus.MemAck  = 1'b1;
                bus.MemData = paddr[7:0];
                pend        = 1'b0;
            end else begin
                bus.MemAck  = 1'b0;
                bus.MemData = 8'($urandom);
                if (pend) waitc--;
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then advance to the next falling edge.
    task automatic tick();
        Reset          = rst_q;
        bus.FrameStart = fs_q;
        bus.LineStart  = ls_q;
        bus.BaseAddr   = base_q;
        respond();
        @(posedge PixelClk);
        @(negedge PixelClk);
        cyc++;
        fs_q = 1'b0;
        ls_q = 1'b0;
    endtask

    initial begin
        rst_q = 1'b1; fs_q = 1'b0; ls_q = 1'b0; base_q = 16'h0000;
        lat_fix = 0; lat_rand = 1'b0; lat_max = 0; pend = 1'b0;
        bus.MemAck = 1'b0; bus.MemData = 8'h00;

        // reset values
        repeat (3) tick();
        chk("rst_memreq", bus.MemReq, 0);
        chk("rst_reqwrite", bus.ReqWrite, 0);
        chk("rst_underrun", bus.Underrun, 0);
        chk("rst_dataout", bus.DataOut, 0);
        chk("rst_writeindex", bus.WriteIndex, 0);
        chk("rst_readindex", bus.ReadIndex, 0);
        rst_q = 1'b0;
        tick();
        chk("rst_release_memreq", bus.MemReq, 1);
        chk("rst_release_addr", bus.MemAddr, 16'h0000);
        repeat (12) tick();

        // zero-latency line: 12 writes of bytes 0x00..0x0B
        base_q = 16'h0100; fs_q = 1'b1; tick();
        repeat (9) tick();
        ls_q = 1'b1; tick();
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.ReqWrite) begin
                chk("zl_windex", bus.WriteIndex, pulses % 3);
                chk("zl_data", bus.DataOut, pulses);
                chk("zl_rindex", bus.ReadIndex, pulses % 3 + 1);
                pulses++;
            end
        end
        chk("zl_pulses", pulses, 12);
        chk("zl_underrun", bus.Underrun, 0);

        // full FIFO: exactly 4 requests without LineStart
        fs_q = 1'b1; tick();
        reqs = 0; prev = bus.MemReq;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.MemReq && !prev) reqs++;
            prev = bus.MemReq;
        end
        chk("full_reqs", reqs, 4);
        chk("full_idle", bus.MemReq, 0);
        ls_q = 1'b1; tick();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.ReqWrite) found = 1'b1;
        end
        chk("full_slot_seen", found, 1);
        chk("full_first_byte", bus.DataOut, 8'h00);
        tick();
        chk("full_rereq", bus.MemReq, 1);
        chk("full_rereq_addr", bus.MemAddr, 16'h0104);

        // slow memory: underrun, sticky until FrameStart
        repeat (40) tick();
        lat_fix = 6; base_q = 16'h0355; fs_q = 1'b1; tick();
        repeat (9) tick();
        ls_q = 1'b1; tick();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.Underrun) found = 1'b1;
        end
        chk("ur_seen", found, 1);
        chk("ur_reqwrite", bus.ReqWrite, 1);
        chk("ur_data", bus.DataOut, 8'h00);
        repeat (40) tick();
        chk("ur_sticky", bus.Underrun, 1);

        // FrameStart with a request pending: late byte discarded, restart at new base
        found = 1'b0; prev = bus.MemReq;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.MemReq && !prev) found = 1'b1;
            prev = bus.MemReq;
        end
        chk("pend_req_seen", found, 1);
        repeat (2) tick();
        chk("pend_held", bus.MemReq, 1);
        base_q = 16'h2000; fs_q = 1'b1; tick();
        chk("fs_clears_underrun", bus.Underrun, 0);
        chk("fs_drops_req", bus.MemReq, 0);
        lat_fix = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.MemReq) found = 1'b1;
        end
        chk("fs_new_req_seen", found, 1);
        chk("fs_new_addr", bus.MemAddr, 16'h2000);
        repeat (20) tick();
        ls_q = 1'b1; tick();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (bus.ReqWrite) found = 1'b1;
        end
        chk("fs_slot_seen", found, 1);
        chk("fs_late_dropped", bus.DataOut, 8'h00);
        chk("fs_first_index", bus.WriteIndex, 0);

        // LineStart at Phase 3 restarts the group
        tick();
        chk("ls3_at_phase3", bus.ReadIndex, 1);
        ls_q = 1'b1; tick();
        chk("ls3_phase0", bus.ReadIndex, 0);
        chk("ls3_no_write", bus.ReqWrite, 0);
        tick();
        tick();
        chk("ls3_write", bus.ReqWrite, 1);
        chk("ls3_index", bus.WriteIndex, 0);

        // randomized latency, line/frame timing and occasional reset
        lat_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            lat_max = (i < 1500) ? 1 : 4;
            if ($urandom_range(39, 0) == 0) ls_q = 1'b1;
            if ($urandom_range(399, 0) == 0) begin
                fs_q   = 1'b1;
                base_q = 16'($urandom);
            end
            rst_q = ($urandom_range(1499, 0) == 0);
            tick();
        end
        rst_q = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
